uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among N_REQ independent requesters, e.g. debug console, status reporter and loopback echo.
- Grants are round-robin and locked per packet. The arbiter holds its grant until the owning requester's beat carrying last=1 is accepted, so lines from different sources never interleave.
- Sits directly upstream of the UART TX block and uses the same data/valid/ready handshake and MAX_BITS character width.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX among N_REQ sources.
// Define UART_ARB_TIMEOUT_EN to add the stalled-owner release (timeout_evt).
module uart_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MAX_BITS = 8
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*MAX_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [MAX_BITS-1:0]       tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
  , output logic                    timeout_evt
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_owner, w_owner_nxt;
  logic [IW-1:0]     r_rr, w_rr_nxt, w_rr_inc;
  logic [IW-1:0]     w_sel;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [N_REQ-1:0]  w_rot;
  logic              w_found;
  logic              w_own_valid, w_own_last;
  logic [MAX_BITS-1:0] w_own_data;
  logic              w_pkt_end, w_release;
  int                w_k, w_idx;

  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_own_data  = req_data[r_owner*MAX_BITS +: MAX_BITS];
  assign w_rr_inc    = (r_owner == IW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
  assign w_pkt_end   = (r_state == LOCKED) & w_own_valid
                     & tx_ready & w_own_last;

  // Rotate so bit 0 is the rr requester; lowest set bit wins.
  assign w_rot = N_REQ'({req_valid, req_valid} >> r_rr);

  always_comb begin
    w_found = 1'b0;
    w_k     = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_k     = k;
      end
    end
    w_idx = int'(r_rr) + w_k;
    if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
    w_sel = IW'(w_idx);
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_evt;

  assign w_release = (r_state == LOCKED) & ~w_own_valid
                   & (r_cnt == CW'(TIMEOUT_CYCLES-1));
  assign timeout_evt = r_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_evt <= 1'b0;
    end else begin
      r_evt <= w_release;
      if (r_state != LOCKED || w_own_valid || w_release)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_release = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = LOCKED;
          w_grant_nxt = N_REQ'(1) << w_sel;
          w_owner_nxt = w_sel;
        end
      end
      LOCKED: begin
        if (w_pkt_end || w_release) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = w_rr_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    if (r_state == LOCKED) begin
      tx_data   = w_own_data;
      tx_valid  = w_own_valid;
      req_ready = r_grant & {N_REQ{tx_ready}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state == LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=2, MAX_BITS=8).
// Requesters are modelled as beat queues {last, data}.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic        timeout_evt;
`endif

  uart_tx_arbiter #(
    .N_REQ(2),
    .MAX_BITS(8)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_evt(timeout_evt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [63:0] rdy_pat;

  logic [7:0]  cyc_data[64];
  logic        cyc_valid[64];
  logic [1:0]  cyc_gnt[64];
  logic [1:0]  cyc_rdy[64];
  logic        cyc_busy[64];
  logic        cyc_evt[64];

  logic [7:0]  log_data[$];
  logic [1:0]  log_gnt[$];
  int          log_cyc[$];

  task automatic run(input int n);
    logic [1:0] acc;
    logic [8:0] h;
    log_data.delete();
    log_gnt.delete();
    log_cyc.delete();
    for (int c = 0; c < n; c++) begin
      h = (q0.size() > 0) ? q0[0] : 9'h000;
      req_valid[0]   = (q0.size() > 0);
      req_data[7:0]  = h[7:0];
      req_last[0]    = h[8];
      h = (q1.size() > 0) ? q1[0] : 9'h000;
      req_valid[1]   = (q1.size() > 0);
      req_data[15:8] = h[7:0];
      req_last[1]    = h[8];
      tx_ready       = rdy_pat[c];
      @(negedge clk);
      cyc_data[c]  = tx_data;
      cyc_valid[c] = tx_valid;
      cyc_gnt[c]   = grant;
      cyc_rdy[c]   = req_ready;
      cyc_busy[c]  = busy;
`ifdef UART_ARB_TIMEOUT_EN
      cyc_evt[c]   = timeout_evt;
`else
      cyc_evt[c]   = 1'b0;
`endif
      acc = req_valid & req_ready;
      if (tx_valid && tx_ready) begin
        log_data.push_back(tx_data);
        log_gnt.push_back(grant);
        log_cyc.push_back(c);
      end
      @(posedge clk);
      #1;
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_data  = 16'h0000;
    tx_ready  = 1'b1;
    rdy_pat   = '1;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_last  = 2'b11;
    req_data  = 16'hA5C3;
    tx_ready  = 1'b1;
    rdy_pat   = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({grant, busy, tx_valid, req_ready} !== 6'b0 || tx_data !== 8'h00)
      $display("FAIL reset_outputs: grant=%b busy=%b txv=%b rdy=%b data=%h, want all 0",
               grant, busy, tx_valid, req_ready, tx_data);
    else n_pass++;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (grant !== 2'b00 || busy !== 1'b0)
      $display("FAIL reset_idle: grant=%b busy=%b, want 00 0", grant, busy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] ed[3] = '{8'h41, 8'h42, 8'h43};
    do_reset();
    q0 = '{9'h041, 9'h042, 9'h143};
    run(6);
    n_total++;
    if (cyc_gnt[0] !== 2'b00)
      $display("FAIL single_first_idle: grant=%b want 00", cyc_gnt[0]);
    else n_pass++;
    n_total++;
    if (cyc_gnt[1] !== 2'b01 || cyc_busy[1] !== 1'b1 || cyc_rdy[1] !== 2'b01)
      $display("FAIL single_grant: grant=%b busy=%b rdy=%b want 01 1 01",
               cyc_gnt[1], cyc_busy[1], cyc_rdy[1]);
    else n_pass++;
    n_total++;
    if (log_data.size() !== 3)
      $display("FAIL single_beats: got %0d beats want 3", log_data.size());
    else begin
      n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (log_data[k] !== ed[k] || log_cyc[k] !== k + 1)
          $display("FAIL single_beat%0d: data=%h cyc=%0d want %h %0d",
                   k, log_data[k], log_cyc[k], ed[k], k + 1);
        else n_pass++;
      end
    end
    n_total++;
    if (cyc_busy[4] !== 1'b0 || cyc_gnt[4] !== 2'b00 || cyc_valid[4] !== 1'b0)
      $display("FAIL single_release: busy=%b grant=%b txv=%b want 0 00 0",
               cyc_busy[4], cyc_gnt[4], cyc_valid[4]);
    else n_pass++;
    // rr is now 1: requester 1 must win a simultaneous request.
    q0 = '{9'h150};
    q1 = '{9'h160};
    run(5);
    n_total++;
    if (log_data.size() !== 2)
      $display("FAIL single_rr_beats: got %0d want 2", log_data.size());
    else begin
      n_pass++;
      n_total++;
      if (log_data[0] !== 8'h60 || log_gnt[0] !== 2'b10 ||
          log_data[1] !== 8'h50 || log_gnt[1] !== 2'b01 || log_cyc[1] !== 3)
        $display("FAIL single_rr_order: %h/%b %h/%b@%0d want 60/10 50/01@3",
                 log_data[0], log_gnt[0], log_data[1], log_gnt[1], log_cyc[1]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ed[4] = '{8'h10, 8'h11, 8'h20, 8'h21};
    logic [1:0] eg[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    int         ec[4] = '{1, 2, 4, 5};
    do_reset();
    q0 = '{9'h010, 9'h111};
    q1 = '{9'h020, 9'h121};
    run(8);
    n_total++;
    if (log_data.size() !== 4)
      $display("FAIL rr_beats: got %0d want 4", log_data.size());
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if (log_data[k] !== ed[k] || log_gnt[k] !== eg[k] || log_cyc[k] !== ec[k])
          $display("FAIL rr_beat%0d: %h/%b@%0d want %h/%b@%0d", k,
                   log_data[k], log_gnt[k], log_cyc[k], ed[k], eg[k], ec[k]);
        else n_pass++;
      end
    end
    n_total++;
    if (cyc_valid[3] !== 1'b0 || cyc_gnt[3] !== 2'b00)
      $display("FAIL rr_bubble: txv=%b grant=%b want 0 00", cyc_valid[3], cyc_gnt[3]);
    else n_pass++;
    q0 = '{9'h130};
    q1 = '{9'h131};
    run(3);
    n_total++;
    if (log_data.size() < 1 || log_data[0] !== 8'h30 || log_gnt[0] !== 2'b01)
      $display("FAIL rr_wrap: first beat %h/%b want 30/01",
               (log_data.size() > 0) ? log_data[0] : 8'hxx,
               (log_gnt.size() > 0) ? log_gnt[0] : 2'bxx);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    q1 = '{9'h040, 9'h041, 9'h142};
    rdy_pat = ~64'h7C;
    run(10);
    for (int c = 2; c <= 6; c++) begin
      n_total++;
      if (cyc_valid[c] !== 1'b1 || cyc_data[c] !== 8'h41 ||
          cyc_rdy[c] !== 2'b00 || cyc_gnt[c] !== 2'b10)
        $display("FAIL stall_c%0d: txv=%b data=%h rdy=%b grant=%b want 1 41 00 10",
                 c, cyc_valid[c], cyc_data[c], cyc_rdy[c], cyc_gnt[c]);
      else n_pass++;
    end
    n_total++;
    if (log_data.size() !== 3 || log_cyc[1] !== 7 || log_data[1] !== 8'h41 ||
        log_cyc[2] !== 8 || log_data[2] !== 8'h42)
      $display("FAIL stall_accept: n=%0d 41@%0d 42@%0d want n=3 41@7 42@8",
               log_data.size(), (log_cyc.size() > 1) ? log_cyc[1] : -1,
               (log_cyc.size() > 2) ? log_cyc[2] : -1);
    else n_pass++;
    rdy_pat = '1;
  endtask

  task automatic test_fairness();
    logic [7:0] ed[3] = '{8'h50, 8'h60, 8'h51};
    logic [1:0] eg[3] = '{2'b01, 2'b10, 2'b01};
    int         ec[3] = '{1, 3, 5};
    do_reset();
    q0 = '{9'h150, 9'h151};
    q1 = '{9'h160};
    run(7);
    n_total++;
    if (log_data.size() !== 3)
      $display("FAIL fair_beats: got %0d want 3", log_data.size());
    else begin
      n_pass++;
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (log_data[k] !== ed[k] || log_gnt[k] !== eg[k] || log_cyc[k] !== ec[k])
          $display("FAIL fair_beat%0d: %h/%b@%0d want %h/%b@%0d", k,
                   log_data[k], log_gnt[k], log_cyc[k], ed[k], eg[k], ec[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    // rr is 1 here, so requester 1 locks first.
    q1 = '{9'h070, 9'h071, 9'h172};
    run(2);
    n_total++;
    if (log_data.size() !== 1 || log_data[0] !== 8'h70 || log_gnt[0] !== 2'b10)
      $display("FAIL rstmid_lock: n=%0d want one beat 70/10", log_data.size());
    else n_pass++;
    rst      = 1'b1;
    tx_ready = 1'b0;
    req_valid = 2'b10;
    req_data  = 16'h7100;
    req_last  = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    q0 = '{9'h180};
    run(3);
    n_total++;
    if (cyc_gnt[0] !== 2'b00 || cyc_valid[0] !== 1'b0 || cyc_busy[0] !== 1'b0)
      $display("FAIL rstmid_idle: grant=%b txv=%b busy=%b want 00 0 0",
               cyc_gnt[0], cyc_valid[0], cyc_busy[0]);
    else n_pass++;
    n_total++;
    if (log_data.size() < 1 || log_data[0] !== 8'h80 || log_gnt[0] !== 2'b01)
      $display("FAIL rstmid_rr: first beat %h/%b want 80/01",
               (log_data.size() > 0) ? log_data[0] : 8'hxx,
               (log_gnt.size() > 0) ? log_gnt[0] : 2'bxx);
    else n_pass++;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int evts;
    do_reset();
    q0 = '{9'h090};
    q1 = '{9'h1A0};
    run(9);
    evts = 0;
    for (int c = 0; c < 9; c++) evts += int'(cyc_evt[c]);
    n_total++;
    if (cyc_gnt[5] !== 2'b01 || cyc_gnt[6] !== 2'b00)
      $display("FAIL to_release: grant c5=%b c6=%b want 01 00", cyc_gnt[5], cyc_gnt[6]);
    else n_pass++;
    n_total++;
    if (cyc_evt[6] !== 1'b1 || evts !== 1)
      $display("FAIL to_evt: evt c6=%b count=%0d want 1 1", cyc_evt[6], evts);
    else n_pass++;
    n_total++;
    if (log_data.size() !== 2 || log_data[1] !== 8'hA0 ||
        log_gnt[1] !== 2'b10 || log_cyc[1] !== 7)
      $display("FAIL to_next: n=%0d want 2 beats, A0/10@7", log_data.size());
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_data  = 16'h0000;
    tx_ready  = 1'b0;
    rdy_pat   = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_fairness();
    test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
